// File: rtl/ddr3_writer_grayscale_pack_if.sv
// Pixel stream, Avalon-MM burst write and address-publish signals of the grayscale DDR3 frame writer.
// master: the writer's view; slave: the view of whatever drives pixels and serves the DDR3 port.
interface ddr3_writer_grayscale_pack_if;
  logic [7:0]   pixel_data;
  logic         pixel_sof;
  logic         pixel_valid;
  logic         pixel_ready;
  logic [26:0]  ddr3_address;
  logic [255:0] ddr3_writedata;
  logic         ddr3_write;
  logic [4:0]   ddr3_burstcount;
  logic         ddr3_waitrequest;
  logic [28:0]  address_out_data;
  logic         address_out_valid;
  logic         sof_error;

  modport master (
    input  pixel_data, pixel_sof, pixel_valid, ddr3_waitrequest,
    output pixel_ready, ddr3_address, ddr3_writedata, ddr3_write, ddr3_burstcount,
           address_out_data, address_out_valid, sof_error
  );

  modport slave (
    output pixel_data, pixel_sof, pixel_valid, ddr3_waitrequest,
    input  pixel_ready, ddr3_address, ddr3_writedata, ddr3_write, ddr3_burstcount,
           address_out_data, address_out_valid, sof_error
  );
endinterface

// File: rtl/ddr3_writer_grayscale_pack.sv
// Packs 8-bit grayscale pixels into 256-bit words and burst-writes whole frames into three rotating DDR3 buffers.
// Optional DDR3_WRITER_TEST_PATTERN_EN replaces pixel data with the column index (mod 256).
module ddr3_writer_grayscale_pack #(
  parameter int unsigned frame_width   = 768,
  parameter int unsigned frame_lines   = 480,
  parameter int unsigned burst_len     = 8,
  parameter int unsigned buffer_base   = 0,
  parameter int unsigned buffer_stride = 'h8000,
  parameter int unsigned fifo_depth    = 64
) (
  input logic                          ddr3clk,
  input logic                          ddr3clk_reset_n,
  ddr3_writer_grayscale_pack_if.master bus
);
  localparam int unsigned AW           = (fifo_depth > 1) ? $clog2(fifo_depth) : 1;
  localparam int unsigned LW           = AW + 1;
  localparam int unsigned FRAME_PIXELS = frame_width * frame_lines;
  localparam int unsigned FRAME_WORDS  = FRAME_PIXELS / 16;

  typedef enum logic {IN_WAIT_SOF, IN_FRAME} in_state_t;
  typedef enum logic [1:0] {W_IDLE, W_BURST, W_PUBLISH} w_state_t;

  in_state_t    in_state, in_state_nxt;
  w_state_t     w_state, w_state_nxt;

  logic         px_xfer;
  logic         accept_px;
  logic         sof_err_nxt;
  logic         sof_error_q;
  logic [31:0]  px_cnt;
  logic [7:0]   px_val;
  logic [255:0] packer;
  logic [255:0] push_word;
  logic         push;

  logic [255:0] mem [fifo_depth];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [LW-1:0] level;

  logic         pop;
  logic         burst_done;
  logic         publish;
  logic [4:0]   beat_cnt;
  logic [31:0]  word_cnt;
  logic [26:0]  addr_q;
  logic [1:0]   buf_idx;
  logic [26:0]  buf_base;
  logic [1:0]   buf_idx_nxt;
  logic [26:0]  buf_base_nxt;

  assign bus.pixel_ready = (level <= LW'(fifo_depth - 2));
  assign px_xfer         = bus.pixel_valid && bus.pixel_ready;

`ifdef DDR3_WRITER_TEST_PATTERN_EN
  logic [31:0] col;

  always_ff @(posedge ddr3clk or negedge ddr3clk_reset_n) begin
    if (!ddr3clk_reset_n)
      col <= '0;
    else if (accept_px)
      col <= (col == 32'(frame_width - 1)) ? '0 : col + 32'd1;
  end

  assign px_val = col[7:0];
`else
  assign px_val = bus.pixel_data;
`endif

  // Input FSM
  always_ff @(posedge ddr3clk or negedge ddr3clk_reset_n) begin
    if (!ddr3clk_reset_n) in_state <= IN_WAIT_SOF;
    else                  in_state <= in_state_nxt;
  end

  always_comb begin
    in_state_nxt = in_state;
    accept_px    = 1'b0;
    sof_err_nxt  = 1'b0;
    unique case (in_state)
      IN_WAIT_SOF: begin
        if (px_xfer && bus.pixel_sof) begin
          accept_px    = 1'b1;
          in_state_nxt = IN_FRAME;
        end
      end
      IN_FRAME: begin
        if (px_xfer) begin
          accept_px   = 1'b1;
          sof_err_nxt = bus.pixel_sof;
          if (px_cnt == 32'(FRAME_PIXELS - 1))
            in_state_nxt = IN_WAIT_SOF;
        end
      end
    endcase
  end

  // px_cnt rests at 0 between frames, so its low nibble is the lane of the pixel being accepted
  assign push_word = {8'h00, px_val, packer[255:16]};
  assign push      = accept_px && (px_cnt[3:0] == 4'hF);

  always_ff @(posedge ddr3clk or negedge ddr3clk_reset_n) begin
    if (!ddr3clk_reset_n) begin
      px_cnt      <= '0;
      packer      <= '0;
      sof_error_q <= 1'b0;
    end else begin
      sof_error_q <= sof_err_nxt;
      if (accept_px) begin
        packer <= push_word;
        px_cnt <= (px_cnt == 32'(FRAME_PIXELS - 1)) ? '0 : px_cnt + 32'd1;
      end
    end
  end

  // Packed-word FIFO, show-ahead read
  always_ff @(posedge ddr3clk) begin
    if (push)
      mem[wr_ptr] <= push_word;
  end

  always_ff @(posedge ddr3clk or negedge ddr3clk_reset_n) begin
    if (!ddr3clk_reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  // Write FSM
  always_ff @(posedge ddr3clk or negedge ddr3clk_reset_n) begin
    if (!ddr3clk_reset_n) w_state <= W_IDLE;
    else                  w_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = w_state;
    pop         = 1'b0;
    burst_done  = 1'b0;
    publish     = 1'b0;
    unique case (w_state)
      W_IDLE: begin
        if (level >= LW'(burst_len))
          w_state_nxt = W_BURST;
      end
      W_BURST: begin
        pop = !bus.ddr3_waitrequest;
        if (pop && (beat_cnt == 5'(burst_len - 1))) begin
          burst_done  = 1'b1;
          w_state_nxt = (word_cnt == 32'(FRAME_WORDS - burst_len)) ? W_PUBLISH : W_IDLE;
        end
      end
      W_PUBLISH: begin
        publish     = 1'b1;
        w_state_nxt = W_IDLE;
      end
      default: w_state_nxt = W_IDLE;
    endcase
  end

  assign buf_idx_nxt  = (buf_idx == 2'd2) ? 2'd0 : buf_idx + 2'd1;
  assign buf_base_nxt = (buf_idx == 2'd2) ? 27'(buffer_base) : buf_base + 27'(buffer_stride);

  always_ff @(posedge ddr3clk or negedge ddr3clk_reset_n) begin
    if (!ddr3clk_reset_n) begin
      beat_cnt <= '0;
      word_cnt <= '0;
      addr_q   <= 27'(buffer_base);
      buf_idx  <= '0;
      buf_base <= 27'(buffer_base);
    end else begin
      if (pop)
        beat_cnt <= burst_done ? '0 : beat_cnt + 5'd1;
      if (burst_done) begin
        addr_q   <= addr_q + 27'(burst_len);
        word_cnt <= (w_state_nxt == W_PUBLISH) ? '0 : word_cnt + 32'(burst_len);
      end else if (publish) begin
        addr_q   <= buf_base_nxt;
        buf_idx  <= buf_idx_nxt;
        buf_base <= buf_base_nxt;
      end
    end
  end

  assign bus.ddr3_write        = (w_state == W_BURST);
  assign bus.ddr3_address      = addr_q;
  assign bus.ddr3_writedata    = bus.ddr3_write ? mem[rd_ptr] : '0;
  assign bus.ddr3_burstcount   = 5'(burst_len);
  assign bus.address_out_valid = publish;
  assign bus.address_out_data  = publish ? {buf_idx, buf_base} : '0;
  assign bus.sof_error         = sof_error_q;
endmodule
